// File: rtl/wx_mem_responder.sv
// Memory-side responder for the compute engine's weight/activation bus: four 1-bit-wide weight
// and activation banks, a valid/ready preload stream, and en gating until compute_finish.
module wx_mem_responder #(
    parameter int unsigned W_ADDR_LEN = 20,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_SEL_LEN  = 2,
    parameter int unsigned X_SEL_LEN  = 2,
    parameter int unsigned W_DEPTH    = 16,
    parameter int unsigned X_DEPTH    = 16,
    parameter int unsigned CNT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_target,
    input  logic [1:0]            ld_sel,
    input  logic [W_ADDR_LEN-1:0] ld_addr,
    input  logic                  ld_data,
    input  logic                  ld_last,
    output logic [CNT_LEN-1:0]    ld_count,
    output logic                  en,
    input  logic                  compute_finish,
    output logic                  done,
    output logic                  err_oob,
    input  logic [W_ADDR_LEN-1:0] w_addr,
    input  logic [W_SEL_LEN-1:0]  w_sel,
    input  logic                  w_wq,
    output logic                  w_data,
    input  logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [X_SEL_LEN-1:0]  x_sel,
    input  logic                  x_wq,
    input  logic                  wx_write,
    output logic                  x_data
);

    localparam int unsigned W_IDX   = $clog2(W_DEPTH);
    localparam int unsigned X_IDX   = $clog2(X_DEPTH);
    localparam int unsigned W_BANKS = 2 ** W_SEL_LEN;
    localparam int unsigned X_BANKS = 2 ** X_SEL_LEN;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e               state_q;
    logic                 ld_ready_q;
    logic                 en_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_LEN-1:0]   cnt_q;

    logic [W_DEPTH-1:0]   wbank_q [W_BANKS];
    logic [X_DEPTH-1:0]   xbank_q [X_BANKS];

    logic                  run;
    logic                  accept;
    logic [X_ADDR_LEN-1:0] ld_x_addr;
    logic                  ld_oob;
    logic                  w_oob;
    logic                  x_oob;
    logic                  oob_evt;

    assign run       = (state_q == StRun);
    assign accept    = ld_valid & ld_ready_q;
    // Activation preloads use only the low address bits before the range check.
    assign ld_x_addr = ld_addr[X_ADDR_LEN-1:0];
    assign ld_oob    = ld_target ? (ld_x_addr >= X_ADDR_LEN'(X_DEPTH))
                                 : (ld_addr >= W_ADDR_LEN'(W_DEPTH));
    assign w_oob     = (w_addr >= W_ADDR_LEN'(W_DEPTH));
    assign x_oob     = (x_addr >= X_ADDR_LEN'(X_DEPTH));
    // Weight writes are never legal, so any attempt during RUN is flagged.
    assign oob_evt   = (accept & ld_oob) | (run & (w_oob | x_oob | w_wq));

    assign w_data   = run & ~w_oob & wbank_q[w_sel][w_addr[W_IDX-1:0]];
    assign x_data   = run & ~x_oob & xbank_q[x_sel][x_addr[X_IDX-1:0]];
    assign ld_ready = ld_ready_q;
    assign en       = en_q;
    assign done     = done_q;
    assign err_oob  = err_q;
    assign ld_count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ld_ready_q <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (oob_evt) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StLoad;
                        ld_ready_q <= 1'b1;
                        done_q     <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_LEN'(1);
                        end
                        if (ld_last) begin
                            state_q    <= StRun;
                            ld_ready_q <= 1'b0;
                            en_q       <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (compute_finish) begin
                        state_q <= StDone;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(W_BANKS); i++) begin
                wbank_q[i] <= '0;
            end
            for (int i = 0; i < int'(X_BANKS); i++) begin
                xbank_q[i] <= '0;
            end
        end else begin
            if (accept && !ld_oob) begin
                if (ld_target) begin
                    xbank_q[ld_sel][ld_addr[X_IDX-1:0]] <= ld_data;
                end else begin
                    wbank_q[ld_sel][ld_addr[W_IDX-1:0]] <= ld_data;
                end
            end
            if (run && x_wq && !x_oob) begin
                xbank_q[x_sel][x_addr[X_IDX-1:0]] <= wx_write;
            end
        end
    end

endmodule
